// File: rtl/serial_subtractor.sv
//============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial two's-complement subtractor computing a - b - bin,
//            one bit per clock, LSB first, with a single registered borrow.
//            start/done handshake, WIDTH-cycle processing latency.
// Options  : SERIAL_SUB_OVF_EN - when defined, a registered signed-overflow
//            flag is produced on ovf; otherwise ovf is tied to 0.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_next;

    // Full-subtractor cell on the current LSBs and the shifted-in result
    always_comb begin
        d_bit    = a_sh[0] ^ b_sh[0] ^ br;
        br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        res_next = {d_bit, res_sh[WIDTH-1:1]};
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

`ifdef SERIAL_SUB_OVF_EN
    logic a_sign;
    logic b_sign;
    logic ovf_q;

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    // Control FSM, operand/result shift registers and output result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_sign <= 1'b0;
            b_sign <= 1'b0;
            ovf_q  <= 1'b0;
`endif
        end else begin
            case (state)
                // DONE accepts a new request exactly like IDLE so that a held
                // start produces back-to-back operations
                IDLE, DONE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        br     <= bin;
                        cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_sign <= a[WIDTH-1];
                        b_sign <= b[WIDTH-1];
`endif
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    br     <= br_next;
                    if (cnt == LAST_BIT) begin
                        // Result is published from the freshly shifted value so
                        // diff never exposes a partially built word
                        diff  <= res_next;
                        bout  <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q <= (a_sign ^ b_sign) & (a_sign ^ d_bit);
`endif
                        state <= DONE;
                    end else begin
                        cnt   <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
